// File: rtl/risc_pkg.sv
// Shared definitions for the 13-bit teaching RISC core: widths, opcode map
// and instruction field positions.
package risc_pkg;

  localparam int unsigned IW   = 13;
  localparam int unsigned PCW  = 6;
  localparam int unsigned OPW  = 4;
  localparam int unsigned REGW = 3;

  localparam int unsigned OP_LSB = 9;
  localparam int unsigned RD_LSB = 6;
  localparam int unsigned RS_LSB = 3;
  localparam int unsigned RT_LSB = 0;

  localparam logic [OPW-1:0] OP_NOP = 4'd0;
  localparam logic [OPW-1:0] OP_ADD = 4'd1;
  localparam logic [OPW-1:0] OP_SUB = 4'd2;
  localparam logic [OPW-1:0] OP_AND = 4'd3;
  localparam logic [OPW-1:0] OP_OR  = 4'd4;
  localparam logic [OPW-1:0] OP_XOR = 4'd5;
  localparam logic [OPW-1:0] OP_INC = 4'd6;
  localparam logic [OPW-1:0] OP_DEC = 4'd7;
  localparam logic [OPW-1:0] OP_NOT = 4'd8;
  localparam logic [OPW-1:0] OP_NEG = 4'd9;
  localparam logic [OPW-1:0] OP_SHR = 4'd10;
  localparam logic [OPW-1:0] OP_SHL = 4'd11;
  localparam logic [OPW-1:0] OP_ROR = 4'd12;
  localparam logic [OPW-1:0] OP_ROL = 4'd13;

  // Everything above the last defined opcode (14, 15) is reserved.
  function automatic logic op_is_illegal(input logic [OPW-1:0] op);
    return op > OP_ROL;
  endfunction

endpackage

// File: rtl/risc_idecode.sv
// Combinational instruction field slicer and reserved-opcode detector;
// shared by the fetch unit and the control unit.
module risc_idecode
  import risc_pkg::*;
(
  input  logic [IW-1:0]   ir,
  output logic [OPW-1:0]  opcode,
  output logic [REGW-1:0] rd,
  output logic [REGW-1:0] rs,
  output logic [REGW-1:0] rt,
  output logic            illegal
);

  always_comb begin
    opcode  = ir[OP_LSB +: OPW];
    rd      = ir[RD_LSB +: REGW];
    rs      = ir[RS_LSB +: REGW];
    rt      = ir[RT_LSB +: REGW];
    illegal = op_is_illegal(opcode);
  end

endmodule

// File: rtl/risc_iunit.sv
// Fetch stage: free-running program counter and instruction register, with
// the latched word decoded into its fields.
module risc_iunit
  import risc_pkg::*;
#(
  parameter logic [PCW-1:0] PC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IW-1:0]   instruction,
  output logic [PCW-1:0]  pc,
  output logic [IW-1:0]   ir,
  output logic [OPW-1:0]  opcode,
  output logic [REGW-1:0] rd,
  output logic [REGW-1:0] rs,
  output logic [REGW-1:0] rt,
  output logic            illegal
);

  logic [PCW-1:0] pc_d, pc_q;
  logic [IW-1:0]  ir_d, ir_q;

  // PC wraps naturally modulo 2^PCW; illegal words are latched like any other.
  always_comb begin
    pc_d = pc_q + PCW'(1);
    ir_d = instruction;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RST;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  assign pc = pc_q;
  assign ir = ir_q;

  risc_idecode u_idecode (
    .ir      (ir_q),
    .opcode  (opcode),
    .rd      (rd),
    .rs      (rs),
    .rt      (rt),
    .illegal (illegal)
  );

endmodule

// File: tb/tb_risc_iunit.sv
// Self-checking bench for risc_iunit: vector table through a scoreboard queue,
// plus reset, wrap and asynchronous mid-run reset sequences.
module tb_risc_iunit;

  logic        clk;
  logic        rst_n;
  logic [12:0] instruction;
  logic [5:0]  pc;
  logic [12:0] ir;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs, rt;
  logic        illegal;

  risc_iunit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .pc          (pc),
    .ir          (ir),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] instr;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [5:0]  pc;
    logic [12:0] ir;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[15];
  logic [5:0]  exp_pc;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one word, push the expected post-edge state, then pop and compare.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    instruction = v.instr;
    e.pc  = exp_pc + 6'd1;
    e.ir  = v.instr;
    e.op  = v.op;
    e.rd  = v.rd;
    e.rs  = v.rs;
    e.rt  = v.rt;
    e.ill = v.ill;
    sb.push_back(e);
    exp_pc = exp_pc + 6'd1;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_pc"},  16'(pc),      16'(e.pc));
      chk({tag, "_ir"},  16'(ir),      16'(e.ir));
      chk({tag, "_op"},  16'(opcode),  16'(e.op));
      chk({tag, "_rd"},  16'(rd),      16'(e.rd));
      chk({tag, "_rs"},  16'(rs),      16'(e.rs));
      chk({tag, "_rt"},  16'(rt),      16'(e.rt));
      chk({tag, "_ill"}, 16'(illegal), 16'(e.ill));
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 6'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t nop;
    nop = '{13'h0000, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0};

    vecs[0]  = '{13'h0208, 4'd1,  3'd0, 3'd1, 3'd0, 1'b0};
    vecs[1]  = '{13'h05F1, 4'd2,  3'd7, 3'd6, 3'd1, 1'b0};
    vecs[2]  = '{13'h06AA, 4'd3,  3'd2, 3'd5, 3'd2, 1'b0};
    vecs[3]  = '{13'h08E3, 4'd4,  3'd3, 3'd4, 3'd3, 1'b0};
    vecs[4]  = '{13'h0B24, 4'd5,  3'd4, 3'd4, 3'd4, 1'b0};
    vecs[5]  = '{13'h0D45, 4'd6,  3'd5, 3'd0, 3'd5, 1'b0};
    vecs[6]  = '{13'h0F86, 4'd7,  3'd6, 3'd0, 3'd6, 1'b0};
    vecs[7]  = '{13'h11C7, 4'd8,  3'd7, 3'd0, 3'd7, 1'b0};
    vecs[8]  = '{13'h1200, 4'd9,  3'd0, 3'd0, 3'd0, 1'b0};
    vecs[9]  = '{13'h1441, 4'd10, 3'd1, 3'd0, 3'd1, 1'b0};
    vecs[10] = '{13'h1682, 4'd11, 3'd2, 3'd0, 3'd2, 1'b0};
    vecs[11] = '{13'h18C3, 4'd12, 3'd3, 3'd0, 3'd3, 1'b0};
    vecs[12] = '{13'h1B04, 4'd13, 3'd4, 3'd0, 3'd4, 1'b0};
    vecs[13] = '{13'h1C00, 4'd14, 3'd0, 3'd0, 3'd0, 1'b1};
    vecs[14] = '{13'h1FFF, 4'd15, 3'd7, 3'd7, 3'd7, 1'b1};

    // Reset held with the clock running and a live word on the input.
    rst_n = 1'b0;
    instruction = 13'h0208;
    exp_pc = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",  16'(pc),      16'd0);
    chk("rst_ir",  16'(ir),      16'd0);
    chk("rst_op",  16'(opcode),  16'd0);
    chk("rst_rd",  16'(rd),      16'd0);
    chk("rst_ill", 16'(illegal), 16'd0);
    rst_n = 1'b1;

    // Sequential fetch, full op sweep, then reserved opcodes.
    for (int i = 0; i < 15; i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // Wrap: 64 clocks from reset return pc to 0, 65 gives 1.
    do_reset();
    for (int i = 0; i < 65; i++)
      step(nop, $sformatf("wrap%0d", i));
    chk("wrap_final_pc", 16'(pc), 16'd1);

    // Asynchronous reset between edges at pc=5.
    do_reset();
    for (int i = 0; i < 5; i++)
      step(vecs[i], $sformatf("pre%0d", i));
    chk("pre_async_pc", 16'(pc), 16'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", 16'(pc),     16'd0);
    chk("async_ir", 16'(ir),     16'd0);
    chk("async_op", 16'(opcode), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 6'd0;
    step(vecs[1], "post0");
    step(vecs[2], "post1");

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
